// File: rtl/izh_neuron_scheduler_pkg.sv
// Shared constants, enums and per-behaviour Izhikevich parameter tables for the
// neuron scheduler. All fixed-point values use sign + 8 integer + 9 fraction bits.
package izh_neuron_scheduler_pkg;

    localparam int IZH_WIDTH = 18;
    localparam int IZH_FRAC  = 9;

    typedef logic signed [IZH_WIDTH-1:0] fx_t;

    typedef enum logic [2:0] {
        BEH_RS  = 3'd0,
        BEH_IB  = 3'd1,
        BEH_CH  = 3'd2,
        BEH_FS  = 3'd3,
        BEH_TC  = 3'd4,
        BEH_RZ  = 3'd5,
        BEH_LTS = 3'd6,
        BEH_RSV = 3'd7
    } beh_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2
    } st_e;

    function automatic fx_t fx_from_int(input int n);
        return fx_t'(n * (1 << IZH_FRAC));
    endfunction

    localparam fx_t V_RESET = fx_t'(-65 * (1 << IZH_FRAC));
    localparam fx_t U_RESET = fx_t'(8 * (1 << IZH_FRAC));
    localparam fx_t PEAK    = fx_t'(30 * (1 << IZH_FRAC));

    // Fractional constants are rounded to the nearest 1/512.
    function automatic fx_t izh_a(input logic [2:0] sel);
        case (sel)
            BEH_FS, BEH_RZ: return fx_t'(51);
            default:        return fx_t'(10);
        endcase
    endfunction

    function automatic fx_t izh_b(input logic [2:0] sel);
        case (sel)
            BEH_TC, BEH_LTS: return fx_t'(128);
            BEH_RZ:          return fx_t'(133);
            default:         return fx_t'(102);
        endcase
    endfunction

    function automatic fx_t izh_c(input logic [2:0] sel);
        case (sel)
            BEH_IB:  return fx_from_int(-55);
            BEH_CH:  return fx_from_int(-50);
            default: return V_RESET;
        endcase
    endfunction

    function automatic fx_t izh_d(input logic [2:0] sel);
        case (sel)
            BEH_IB:                         return fx_from_int(4);
            BEH_CH, BEH_FS, BEH_RZ, BEH_LTS: return fx_from_int(2);
            BEH_TC:                         return fx_t'(26);
            default:                        return U_RESET;
        endcase
    endfunction

endpackage

// File: rtl/izh_neuron_scheduler_if.sv
// Request/acknowledge link between the neuron scheduler and the shared
// Izhikevich update datapath.
interface izh_neuron_scheduler_if #(
    parameter int WIDTH = 18
) ();
    logic                    dp_req;
    logic [2:0]              dp_sel;
    logic signed [WIDTH-1:0] dp_v;
    logic signed [WIDTH-1:0] dp_u;
    logic signed [WIDTH-1:0] dp_i;
    logic                    dp_ack;
    logic signed [WIDTH-1:0] dp_v_nxt;
    logic signed [WIDTH-1:0] dp_u_nxt;
    logic                    dp_spike;

    modport master (
        output dp_req, dp_sel, dp_v, dp_u, dp_i,
        input  dp_ack, dp_v_nxt, dp_u_nxt, dp_spike
    );

    modport slave (
        input  dp_req, dp_sel, dp_v, dp_u, dp_i,
        output dp_ack, dp_v_nxt, dp_u_nxt, dp_spike
    );
endinterface

// File: rtl/izh_neuron_scheduler.sv
// Time-multiplexes one shared Izhikevich update datapath across N_NEURONS
// neurons, holding their v/u state and behaviour select locally.
module izh_neuron_scheduler
    import izh_neuron_scheduler_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = IZH_WIDTH,
    parameter int FRAC      = IZH_FRAC,
    localparam int IDW      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_ena,
    input  logic                 i_tick,
    output logic [IDW-1:0]       o_cur_idx,
    input  logic [7:0]           i_cur_in,
    input  logic                 i_cfg_we,
    input  logic [IDW-1:0]       i_cfg_idx,
    input  logic [2:0]           i_cfg_sel,
    izh_neuron_scheduler_if.master dp,
    output logic                 o_spike_vld,
    output logic [IDW-1:0]       o_spike_id,
    output logic                 o_step_done,
    output logic                 o_busy,
    output logic                 o_overrun,
    input  logic [IDW-1:0]       i_mon_idx,
    output logic [7:0]           o_mon_v
);

    localparam logic [IDW-1:0] LAST_IDX = IDW'(N_NEURONS - 1);
    localparam logic [IDW:0]   N_EXT    = (IDW + 1)'(N_NEURONS);

    st_e                     r_state;
    st_e                     w_next;
    logic [IDW-1:0]          r_idx;
    logic signed [WIDTH-1:0] r_v   [N_NEURONS];
    logic signed [WIDTH-1:0] r_u   [N_NEURONS];
    logic [2:0]              r_sel [N_NEURONS];
    logic signed [WIDTH-1:0] r_v_lat;
    logic signed [WIDTH-1:0] r_u_lat;
    logic                    r_spk_lat;
    logic                    r_overrun;

    logic                    w_cfg_ok;
    logic [2:0]              w_cfg_sel;
    logic                    w_mon_ok;
    logic signed [WIDTH-1:0] w_cur;
    logic                    w_last;

    assign w_cfg_ok  = ({1'b0, i_cfg_idx} < N_EXT);
    assign w_mon_ok  = ({1'b0, i_mon_idx} < N_EXT);
    assign w_last    = (r_idx == LAST_IDX);
    // Reserved behaviour code is stored as RS so downstream never sees it.
    assign w_cfg_sel = (i_cfg_sel == BEH_RSV) ? BEH_RS : i_cfg_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (i_ena) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_tick)   w_next = ST_REQ;
            ST_REQ:  if (dp.dp_ack) w_next = ST_WB;
            ST_WB:   w_next = w_last ? ST_IDLE : ST_REQ;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        dp.dp_req   = (r_state == ST_REQ);
        o_busy      = (r_state != ST_IDLE);
        o_step_done = (r_state == ST_WB) && w_last;
        o_spike_vld = (r_state == ST_WB) && r_spk_lat;
    end

    // Per-neuron state, result latch and sequencing index; all frozen by i_ena=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_v_lat   <= '0;
            r_u_lat   <= '0;
            r_spk_lat <= 1'b0;
            r_overrun <= 1'b0;
            for (int n = 0; n < N_NEURONS; n++) begin
                r_v[n]   <= WIDTH'(V_RESET);
                r_u[n]   <= WIDTH'(U_RESET);
                r_sel[n] <= BEH_RS;
            end
        end else if (i_ena) begin
            if (i_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_idx <= '0;
                    if (i_cfg_we && w_cfg_ok) begin
                        r_sel[i_cfg_idx] <= w_cfg_sel;
                        r_v[i_cfg_idx]   <= WIDTH'(izh_c(w_cfg_sel));
                        r_u[i_cfg_idx]   <= WIDTH'(izh_d(w_cfg_sel));
                    end
                end
                ST_REQ: begin
                    if (dp.dp_ack) begin
                        r_v_lat   <= dp.dp_v_nxt;
                        r_u_lat   <= dp.dp_u_nxt;
                        r_spk_lat <= dp.dp_spike;
                    end
                end
                ST_WB: begin
                    r_v[r_idx] <= r_v_lat;
                    r_u[r_idx] <= r_u_lat;
                    r_idx      <= w_last ? '0 : r_idx + 1'b1;
                end
                default: r_idx <= '0;
            endcase
        end
    end

    always_comb begin
        w_cur              = '0;
        w_cur[FRAC +: 8]   = i_cur_in;
    end

    assign dp.dp_v    = r_v[r_idx];
    assign dp.dp_u    = r_u[r_idx];
    assign dp.dp_sel  = r_sel[r_idx];
    assign dp.dp_i    = w_cur;
    assign o_cur_idx  = r_idx;
    assign o_spike_id = r_idx;
    assign o_overrun  = r_overrun;
    assign o_mon_v    = w_mon_ok ? r_v[i_mon_idx][FRAC +: 8] : 8'd0;

endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Directed bench for izh_neuron_scheduler with a behavioural datapath stub whose
// wait states, spiking neuron and stray acks are set per scenario.
module tb_izh_neuron_scheduler;
    import izh_neuron_scheduler_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           ena;
    logic           tick;
    logic [IDW-1:0] cur_idx;
    logic [7:0]     cur_in;
    logic           cfg_we;
    logic [IDW-1:0] cfg_idx;
    logic [2:0]     cfg_sel;
    logic           spike_vld;
    logic [IDW-1:0] spike_id;
    logic           step_done;
    logic           busy;
    logic           overrun;
    logic [IDW-1:0] mon_idx;
    logic [7:0]     mon_v;

    int checks   = 0;
    int failures = 0;

    int   waits     = 0;
    int   spike_n   = -1;
    logic force_ack = 1'b0;
    int   wcnt;

    izh_neuron_scheduler_if #(.WIDTH(18)) dpif ();

    izh_neuron_scheduler #(.N_NEURONS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_ena      (ena),
        .i_tick     (tick),
        .o_cur_idx  (cur_idx),
        .i_cur_in   (cur_in),
        .i_cfg_we   (cfg_we),
        .i_cfg_idx  (cfg_idx),
        .i_cfg_sel  (cfg_sel),
        .dp         (dpif.master),
        .o_spike_vld(spike_vld),
        .o_spike_id (spike_id),
        .o_step_done(step_done),
        .o_busy     (busy),
        .o_overrun  (overrun),
        .i_mon_idx  (mon_idx),
        .o_mon_v    (mon_v)
    );

    always #5 clk = ~clk;

    // Stub: v' = v + I, u' = u + 1, acked after 'waits' idle cycles of dp_req.
    assign cur_in        = 8'd4 + {6'd0, cur_idx};
    assign dpif.dp_ack   = force_ack | (dpif.dp_req & ena & (wcnt == waits));
    assign dpif.dp_v_nxt = dpif.dp_v + dpif.dp_i;
    assign dpif.dp_u_nxt = dpif.dp_u + 18'sd1;
    assign dpif.dp_spike = (spike_n >= 0) && (int'(cur_idx) == spike_n);

    always_ff @(posedge clk) begin
        if (rst || !dpif.dp_req) wcnt <= 0;
        else if (dpif.dp_ack)    wcnt <= 0;
        else if (ena)            wcnt <= wcnt + 1;
    end

    task automatic do_reset();
        rst = 1'b1; ena = 1'b1; tick = 1'b0; cfg_we = 1'b0;
        cfg_idx = '0; cfg_sel = '0; mon_idx = '0; force_ack = 1'b0;
        waits = 0; spike_n = -1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_step(input int tick_at, input int cfg_at,
                            output int cyc, output int ndone, output int nspk,
                            output int spk_id, output int spk_cyc,
                            output int nreq, output int sel1);
        cyc = 0; ndone = 0; nspk = 0; spk_id = -1; spk_cyc = 0; nreq = 0; sel1 = -1;
        tick = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            tick   = (k == tick_at);
            cfg_we = (k == cfg_at);
            if (dpif.dp_req) nreq++;
            if (dpif.dp_req && cur_idx == 2'd1) sel1 = int'(dpif.dp_sel);
            if (spike_vld) begin nspk++; spk_id = int'(spike_id); spk_cyc = k; end
            if (step_done) begin ndone++; if (cyc == 0) cyc = k; end
            if (cyc != 0 && k >= cyc + 3) break;
        end
        tick = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_v [N];
        exp_v = '{8'hBF, 8'hBF, 8'hBF, 8'hBF};
        do_reset();
        checks++; if (busy !== 1'b0 || dpif.dp_req !== 1'b0 || overrun !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl busy=%b req=%b ovr=%b want 000", busy, dpif.dp_req, overrun); end
        checks++; if (spike_vld !== 1'b0 || step_done !== 1'b0 || cur_idx !== 2'd0) begin
            failures++; $display("FAIL reset_pulses spk=%b done=%b idx=%0d want 0 0 0", spike_vld, step_done, cur_idx); end
        checks++; if (dpif.dp_v !== -18'sd33280 || dpif.dp_u !== 18'sd4096 || dpif.dp_sel !== 3'd0) begin
            failures++; $display("FAIL reset_dp v=%0d u=%0d sel=%0d want -33280 4096 0", dpif.dp_v, dpif.dp_u, dpif.dp_sel); end
        for (int n = 0; n < N; n++) begin
            mon_idx = IDW'(n); #1;
            checks++; if (mon_v !== exp_v[n]) begin
                failures++; $display("FAIL reset_mon%0d got=%h want=%h", n, mon_v, exp_v[n]); end
        end
    endtask

    task automatic test_zero_wait();
        int cyc, nd, ns, sid, sc, nr, s1;
        logic [7:0] exp_v [N];
        exp_v = '{8'hC3, 8'hC4, 8'hC5, 8'hC6};
        do_reset();
        run_step(0, 0, cyc, nd, ns, sid, sc, nr, s1);
        checks++; if (cyc != 8 || nd != 1) begin
            failures++; $display("FAIL zw_latency cyc=%0d done=%0d want 8 1", cyc, nd); end
        checks++; if (nr != 4 || ns != 0) begin
            failures++; $display("FAIL zw_req req_cycles=%0d spikes=%0d want 4 0", nr, ns); end
        checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin
            failures++; $display("FAIL zw_idle busy=%b ovr=%b want 0 0", busy, overrun); end
        for (int n = 0; n < N; n++) begin
            mon_idx = IDW'(n); #1;
            checks++; if (mon_v !== exp_v[n]) begin
                failures++; $display("FAIL zw_mon%0d got=%h want=%h", n, mon_v, exp_v[n]); end
        end
        mon_idx = 2'd0; #1;
        checks++; if (dpif.dp_u !== 18'sd4097) begin
            failures++; $display("FAIL zw_u0 got=%0d want=4097", dpif.dp_u); end
    endtask

    task automatic test_wait_states();
        int cyc, nd, ns, sid, sc, nr, s1;
        do_reset();
        waits = 3;
        run_step(0, 0, cyc, nd, ns, sid, sc, nr, s1);
        checks++; if (cyc != 20 || nd != 1) begin
            failures++; $display("FAIL ws_latency cyc=%0d done=%0d want 20 1", cyc, nd); end
        checks++; if (nr != 16) begin
            failures++; $display("FAIL ws_req req_cycles=%0d want 16", nr); end
        mon_idx = 2'd3; #1;
        checks++; if (mon_v !== 8'hC6) begin
            failures++; $display("FAIL ws_mon3 got=%h want=c6", mon_v); end
    endtask

    task automatic test_spike();
        int cyc, nd, ns, sid, sc, nr, s1;
        do_reset();
        spike_n = 2;
        run_step(0, 0, cyc, nd, ns, sid, sc, nr, s1);
        checks++; if (ns != 1 || sid != 2 || sc != 6) begin
            failures++; $display("FAIL spike count=%0d id=%0d cyc=%0d want 1 2 6", ns, sid, sc); end
    endtask

    task automatic test_overrun();
        int cyc, nd, ns, sid, sc, nr, s1;
        do_reset();
        run_step(3, 0, cyc, nd, ns, sid, sc, nr, s1);
        checks++; if (cyc != 8 || nd != 1) begin
            failures++; $display("FAIL ovr_step cyc=%0d done=%0d want 8 1", cyc, nd); end
        checks++; if (overrun !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL ovr_flag ovr=%b busy=%b want 1 0", overrun, busy); end
        repeat (3) @(negedge clk);
        checks++; if (overrun !== 1'b1) begin
            failures++; $display("FAIL ovr_sticky got=%b want=1", overrun); end
    endtask

    task automatic test_cfg();
        int cyc, nd, ns, sid, sc, nr, s1;
        do_reset();
        cfg_idx = 2'd1; cfg_sel = 3'd2; cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        mon_idx = 2'd1; #1;
        checks++; if (mon_v !== 8'hCE) begin
            failures++; $display("FAIL cfg_idle_mon1 got=%h want=ce", mon_v); end
        mon_idx = 2'd0; #1;
        checks++; if (mon_v !== 8'hBF) begin
            failures++; $display("FAIL cfg_other_mon0 got=%h want=bf", mon_v); end
        cfg_sel = 3'd0;
        run_step(0, 2, cyc, nd, ns, sid, sc, nr, s1);
        checks++; if (s1 != 2) begin
            failures++; $display("FAIL cfg_busy_sel got=%0d want=2", s1); end
        mon_idx = 2'd1; #1;
        checks++; if (mon_v !== 8'hD3) begin
            failures++; $display("FAIL cfg_busy_mon1 got=%h want=d3", mon_v); end
    endtask

    task automatic test_stray_ack();
        do_reset();
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        mon_idx = 2'd0; #1;
        checks++; if (busy !== 1'b0 || mon_v !== 8'hBF || spike_vld !== 1'b0) begin
            failures++; $display("FAIL stray_ack busy=%b mon0=%h spk=%b want 0 bf 0", busy, mon_v, spike_vld); end
    endtask

    task automatic test_ena_rst();
        int k;
        logic bad;
        do_reset();
        waits = 1;
        mon_idx = 2'd0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        ena = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (dpif.dp_req !== 1'b1 || busy !== 1'b1 || cur_idx !== 2'd0 ||
                step_done !== 1'b0 || dpif.dp_v !== -18'sd33280) bad = 1'b1;
        end
        checks++; if (bad) begin
            failures++; $display("FAIL ena_freeze req=%b busy=%b idx=%0d want 1 1 0", dpif.dp_req, busy, cur_idx); end
        ena = 1'b1;
        k = 0;
        while (cur_idx !== 2'd1 && k < 20) begin @(negedge clk); k++; end
        checks++; if (k != 3) begin
            failures++; $display("FAIL ena_resume cycles=%0d want=3", k); end
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        #1;
        checks++; if (mon_v !== 8'hC3 || overrun !== 1'b1) begin
            failures++; $display("FAIL pre_rst mon0=%h ovr=%b want c3 1", mon_v, overrun); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || dpif.dp_req !== 1'b0 || overrun !== 1'b0 || cur_idx !== 2'd0 || mon_v !== 8'hBF) begin
            failures++; $display("FAIL mid_rst busy=%b req=%b ovr=%b idx=%0d mon0=%h want 0 0 0 0 bf",
                                 busy, dpif.dp_req, overrun, cur_idx, mon_v); end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; tick = 1'b0; cfg_we = 1'b0;
        cfg_idx = '0; cfg_sel = '0; mon_idx = '0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_spike();
        test_overrun();
        test_cfg();
        test_stray_ack();
        test_ena_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
